// File: rtl/clk_div_gen.sv
// Programmable clock-enable divider: main/sub tick strobes and 50%-duty divided square waves.
// Optional syncIn phase-alignment input is compiled in when CLK_DIV_SYNC_IN_EN is defined.
module clk_div_gen #(
  parameter int CNT_W         = 8,
  parameter int DEFAULT_RATIO = 64,
  parameter int SUB_SHIFT     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef CLK_DIV_SYNC_IN_EN
  input  logic             syncIn,
`endif
  input  logic [CNT_W-1:0] ratioIn,
  input  logic             ratioLoad,
  output logic             ratioBusy,
  output logic             tickOut,
  output logic             tick8x,
  output logic             clkOut,
  output logic             clkOut8x,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_RATIO = CNT_W'(2);
  localparam logic [CNT_W-1:0] RST_RATIO = CNT_W'(DEFAULT_RATIO);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] sub_q, sub_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             tick8x_q, tick8x_d;
  logic             clk_q, clk_d;
  logic             clk8x_q, clk8x_d;

  logic             sync_w;
  logic [CNT_W-1:0] sub_raw, sub_len, next_sub_raw, next_sub_len;
  logic             wrap, sub_wrap, apply;

`ifdef CLK_DIV_SYNC_IN_EN
  assign sync_w = syncIn;
`else
  assign sync_w = 1'b0;
`endif

  // Load/busy handshake: ratioLoad is a single-cycle request with no ready; a
  // request always captures ratioIn (clamped to >= 2) into the shadow and raises
  // ratioBusy, overwriting any value still pending. ratioBusy drops in the cycle
  // the shadow becomes the active ratio (main wrap with en=1, or syncIn).
  always_comb begin
    count_d  = count_q;
    sub_d    = sub_q;
    ratio_d  = ratio_q;
    shadow_d = shadow_q;
    busy_d   = busy_q;
    tick_d   = 1'b0;
    tick8x_d = 1'b0;

    sub_raw  = ratio_q >> SUB_SHIFT;
    sub_len  = (sub_raw == '0) ? ONE : sub_raw;
    wrap     = (count_q == ratio_q - ONE);
    sub_wrap = (sub_q == sub_len - ONE) || wrap;
    apply    = busy_q && (sync_w || (en && wrap));

    if (sync_w) begin
      count_d = '0;
      sub_d   = '0;
    end else if (en) begin
      count_d  = wrap ? '0 : count_q + ONE;
      sub_d    = sub_wrap ? '0 : sub_q + ONE;
      tick_d   = wrap;
      tick8x_d = sub_wrap;
    end

    if (apply) begin
      ratio_d = shadow_q;
      busy_d  = 1'b0;
    end

    // A same-cycle request lands after the apply so it waits for the next boundary.
    if (ratioLoad) begin
      shadow_d = (ratioIn < MIN_RATIO) ? MIN_RATIO : ratioIn;
      busy_d   = 1'b1;
    end

    // Square waves follow the ratio that governs the upcoming count values.
    next_sub_raw = ratio_d >> SUB_SHIFT;
    next_sub_len = (next_sub_raw == '0) ? ONE : next_sub_raw;
    clk_d        = (count_d < (ratio_d >> 1));
    clk8x_d      = (sub_d < (next_sub_len >> 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      sub_q    <= '0;
      ratio_q  <= RST_RATIO;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      tick8x_q <= 1'b0;
      clk_q    <= 1'b0;
      clk8x_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      sub_q    <= sub_d;
      ratio_q  <= ratio_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
      tick8x_q <= tick8x_d;
      clk_q    <= clk_d;
      clk8x_q  <= clk8x_d;
    end
  end

  assign ratioBusy = busy_q;
  assign tickOut   = tick_q;
  assign tick8x    = tick8x_q;
  assign clkOut    = clk_q;
  assign clkOut8x  = clk8x_q;
  assign count     = count_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: a position-based reference model fills an
// expected queue each cycle; every scenario task pops and compares the DUT outputs.
module tb_clk_div_gen;

  localparam int W = 8;
`ifdef CLK_DIV_SYNC_IN_EN
  localparam bit HAS_SYNC = 1'b1;
`else
  localparam bit HAS_SYNC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         syncIn = 1'b0;
  logic [W-1:0] ratioIn = '0;
  logic         ratioLoad = 1'b0;
  logic         ratioBusy, tickOut, tick8x, clkOut, clkOut8x;
  logic [W-1:0] count;

  clk_div_gen #(.CNT_W(W), .DEFAULT_RATIO(64), .SUB_SHIFT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
`ifdef CLK_DIV_SYNC_IN_EN
    .syncIn    (syncIn),
`endif
    .ratioIn   (ratioIn),
    .ratioLoad (ratioLoad),
    .ratioBusy (ratioBusy),
    .tickOut   (tickOut),
    .tick8x    (tick8x),
    .clkOut    (clkOut),
    .clkOut8x  (clkOut8x),
    .count     (count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [12:0] exp_q[$];

  // Reference model: position within the current period plus ratio bookkeeping.
  int m_p = 0;
  int m_r = 64;
  int m_shadow = 0;
  bit m_busy = 1'b0;

  function automatic int sub_len(input int r);
    int s;
    s = r >> 3;
    return (s < 1) ? 1 : s;
  endfunction

  function automatic logic [12:0] pack_exp(input bit tk, input bit t8);
    int s;
    bit c, c8;
    s  = sub_len(m_r);
    c  = (m_p < (m_r >> 1));
    c8 = ((m_p % s) < (s >> 1));
    return {m_busy, tk, t8, c, c8, 8'(m_p)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {ratioBusy, tickOut, tick8x, clkOut, clkOut8x, count};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit r_i, input bit e_i, input bit l_i,
                             input bit s_i, input int rin);
    bit tk, t8;
    int s;
    rst       = r_i;
    en        = e_i;
    ratioLoad = l_i;
    ratioIn   = W'(rin);
    syncIn    = s_i & HAS_SYNC;
    if (r_i) begin
      m_p = 0; m_r = 64; m_shadow = 0; m_busy = 1'b0;
      exp_q.push_back(13'h0);
    end else begin
      tk = 1'b0;
      t8 = 1'b0;
      if (s_i && HAS_SYNC) begin
        m_p = 0;
        if (m_busy) begin m_r = m_shadow; m_busy = 1'b0; end
      end else if (e_i) begin
        s = sub_len(m_r);
        if (m_p == m_r - 1) begin
          m_p = 0; tk = 1'b1; t8 = 1'b1;
          if (m_busy) begin m_r = m_shadow; m_busy = 1'b0; end
        end else begin
          m_p = m_p + 1;
          t8 = ((m_p % s) == 0);
        end
      end
      if (l_i) begin
        m_shadow = (rin < 2) ? 2 : rin;
        m_busy = 1'b1;
      end
      exp_q.push_back(pack_exp(tk, t8));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [12:0] e, g;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, (i == 1), 1'b0, 33);
      e = exp_q.pop_front(); g = dut_vec(); total++;
      if (g !== e) begin bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, g, e); end
    end
  endtask

  task automatic test_default_rate();
    logic [12:0] e, g;
    int t_prev, t_last;
    t_prev = -1; t_last = -1;
    for (int i = 0; i < 130; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
      e = exp_q.pop_front(); g = dut_vec(); total++;
      if (g !== e) begin bad++; $display("FAIL default_rate cyc=%0d got=%h exp=%h", cyc, g, e); end
      if (tickOut === 1'b1) begin t_prev = t_last; t_last = cyc; end
    end
    total++;
    if (t_prev < 0 || (t_last - t_prev) != 64) begin
      bad++; $display("FAIL default_spacing got=%0d exp=64", t_last - t_prev);
    end
  endtask

  task automatic test_ratio_change();
    logic [12:0] e, g;
    int k, n, t_prev, t_last;
    k = (10 - m_p + m_r) % m_r;
    n = k + 1 + 53 + 45;
    t_prev = -1; t_last = -1;
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'b0, 1'b1, (i == k), 1'b0, 20);
      e = exp_q.pop_front(); g = dut_vec(); total++;
      if (g !== e) begin bad++; $display("FAIL ratio_change cyc=%0d got=%h exp=%h", cyc, g, e); end
      if (tickOut === 1'b1) begin t_prev = t_last; t_last = cyc; end
    end
    total++;
    if (t_prev < 0 || (t_last - t_prev) != 20) begin
      bad++; $display("FAIL ratio20_spacing got=%0d exp=20", t_last - t_prev);
    end
  endtask

  task automatic test_clamp();
    logic [12:0] e, g;
    for (int i = 0; i < 34; i++) begin
      drive_cycle(1'b0, 1'b1, (i == 0), 1'b0, 0);
      e = exp_q.pop_front(); g = dut_vec(); total++;
      if (g !== e) begin bad++; $display("FAIL clamp cyc=%0d got=%h exp=%h", cyc, g, e); end
    end
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1);
    e = exp_q.pop_front(); g = dut_vec(); total++;
    if (g !== e) begin bad++; $display("FAIL clamp_one cyc=%0d got=%h exp=%h", cyc, g, e); end
  endtask

  task automatic test_en_hold();
    logic [12:0] e, g;
    int t_prev, t_last;
    bit e_i;
    t_prev = -1; t_last = -1;
    for (int i = 0; i < 141; i++) begin
      e_i = !(i >= 96 && i < 101);
      drive_cycle((i < 2), e_i, (i == 90), 1'b0, 64);
      e = exp_q.pop_front(); g = dut_vec(); total++;
      if (g !== e) begin bad++; $display("FAIL en_hold cyc=%0d got=%h exp=%h", cyc, g, e); end
      if (tickOut === 1'b1) begin t_prev = t_last; t_last = cyc; end
    end
    total++;
    if (t_prev < 0 || (t_last - t_prev) != 69) begin
      bad++; $display("FAIL en_hold_spacing got=%0d exp=69", t_last - t_prev);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e, g;
    bit l_i;
    int rin;
    for (int i = 0; i < 178; i++) begin
      l_i = (i == 0) || (i == 3) || (i == 100);
      rin = (i == 0) ? 40 : (i == 3) ? 12 : 50;
      drive_cycle((i == 105) || (i == 106), 1'b1, l_i, 1'b0, rin);
      e = exp_q.pop_front(); g = dut_vec(); total++;
      if (g !== e) begin bad++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, g, e); end
    end
  endtask

  task automatic test_sync();
    logic [12:0] e, g;
    int k;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
    e = exp_q.pop_front(); g = dut_vec(); total++;
    if (g !== e) begin bad++; $display("FAIL sync_reset cyc=%0d got=%h exp=%h", cyc, g, e); end
    k = 50;
    for (int i = 0; i < k + 1 + 70; i++) begin
      drive_cycle(1'b0, 1'b1, (i == 20), (i == k), 30);
      e = exp_q.pop_front(); g = dut_vec(); total++;
      if (g !== e) begin bad++; $display("FAIL sync cyc=%0d got=%h exp=%h", cyc, g, e); end
    end
  endtask

  task automatic test_random();
    logic [12:0] e, g;
    for (int i = 0; i < 1500; i++) begin
      drive_cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 29) == 0), ($urandom_range(0, 199) == 0),
                  int'($urandom_range(0, 255)));
      e = exp_q.pop_front(); g = dut_vec(); total++;
      if (g !== e) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, g, e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_default_rate();
    test_ratio_change();
    test_clamp();
    test_en_hold();
    test_back_to_back();
    if (HAS_SYNC) test_sync();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Parametrised, fully synchronous successor to the fixed ripple divide-by-64 chain.
- A single counter in the `clk` domain generates divided strobes and square waves. Outputs: a main-rate tick, a sub-rate tick (default 8x main rate) and 50%-duty divided clocks.
- The divide ratio is runtime-programmable. A new ratio is applied glitch-free at a period boundary.
- Feeds the decimation filter stages as clock enables, so the design needs no derived clocks.

Parameters:
- CNT_W, 8: counter and ratio width in bits; ratio range 2..2^CNT_W-1.
- DEFAULT_RATIO, 64: active ratio after reset. Must be in 2..2^CNT_W-1.
- SUB_SHIFT, 3: sub-rate period = active ratio >> SUB_SHIFT (default 8x main rate).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; counters hold when low.
- ratioIn  in  CNT_W  requested divide ratio.
- ratioLoad  in  1  one-cycle request to capture ratioIn.
- ratioBusy  out  1  high while a captured ratio waits for the period boundary.
- tickOut  out  1  one-cycle pulse per main period.
- tick8x  out  1  one-cycle pulse per sub period.
- clkOut  out  1  divided square wave, main rate.
- clkOut8x  out  1  divided square wave, sub rate.
- count  out  CNT_W  current main counter value.

Behaviour:
- Reset values: count=0, subCnt=0, active ratio=DEFAULT_RATIO, shadow=0, ratioBusy=0. All tick and clock outputs are 0.
- Reset is synchronous, active-high, and takes priority over every other input.
  - Reset mid-period discards the count and any pending ratio.
  - Reset does not produce a tick.
- R = active ratio; S = max(1, R >> SUB_SHIFT).
- Main counter, when en=1:
  - count <= (count == R-1) ? 0 : count+1.
  - When en=0 the counter holds.
- Sub counter, when en=1:
  - subCnt <= (subCnt == S-1 or count == R-1) ? 0 : subCnt+1.
  - It is re-aligned at every main wrap, so the last sub period may be short when R is not a multiple of 2^SUB_SHIFT.
- tickOut is registered: tickOut <= en && (count == R-1).
  - With en held high, the first pulse is high in the cycle after the R-th rising edge following reset release.
  - Pulse spacing is exactly R cycles.
- tick8x is registered: tick8x <= en && (subCnt == S-1 or count == R-1).
- clkOut is registered: clkOut <= (nextCount < R>>1).
  - High for R>>1 cycles, low for R-(R>>1) cycles.
  - For odd R the low phase is one cycle longer.
  - clkOut holds its level while en=0.
- clkOut8x uses the same rule on nextSubCnt against S>>1. When S=1, clkOut8x stays 0.
- Ratio load handshake:
  - On ratioLoad=1, capture ratioIn into the shadow register and set ratioBusy=1 on the next cycle.
  - Captured values below 2 are clamped to 2.
  - ratioLoad while ratioBusy=1 overwrites the shadow; last request wins and ratioBusy stays 1.
- Ratio apply:
  - On the main wrap cycle (en=1 and count == R-1): R <= shadow and ratioBusy <= 0.
  - The new ratio governs the period starting at count=0.
  - The tick for the wrapping period is still issued.
- ratioLoad in the same cycle as a wrap: the capture happens and waits for the following wrap. The old shadow is not applied in that cycle unless ratioBusy was already 1.
- With en=0 a pending ratio stays pending indefinitely.

Optional Feature:
- Macro: CLK_DIV_SYNC_IN_EN.
- Defined:
  - Adds input port syncIn (1 bit).
  - syncIn=1 forces count and subCnt to 0 on the next edge, regardless of en, so the block phase-aligns to an external frame marker.
  - No tick is issued for the truncated period.
  - A pending ratio is applied at that sync, and ratioBusy clears.
  - Priority: rst > syncIn > en.
- Undefined: no syncIn port; phase is set only by reset.

Test Plan:
- Reset release, en=1, default ratio 64 -> tickOut pulses 1 cycle every 64 cycles; tick8x every 8 cycles, coincident with tickOut. clkOut high 32 / low 32; clkOut8x high 4 / low 4.
- ratioLoad with ratioIn=20 at count=10 -> ratioBusy=1 until the current 64-cycle period ends. Next tickOut spacing is 20. tick8x spacing is 2,2,...: sub ticks fire at counts 1,3,...,17 and at 19 (the wrap), so the last sub period is 2. ratioBusy=0 after the wrap.
- ratioIn=0 loaded -> clamped to 2: tickOut every 2 cycles, clkOut toggles every cycle, tick8x every cycle.
- en toggled low for 5 cycles at count=30 -> count, clkOut and ratioBusy hold. The tick period extends by exactly 5 cycles. No tick or tick8x pulse is issued while en=0.
- Two ratioLoad pulses in the same period (ratioIn=40 then 12) -> only 12 is applied at the wrap. rst asserted with a pending ratio -> ratio returns to 64 and ratioBusy=0.
- With CLK_DIV_SYNC_IN_EN: syncIn at count=50 -> count=0 on the next cycle, no tickOut for that period, next tickOut 64 cycles later.
